cache_victim_writeback: RTL and testbench

//  Consumer side of victim selection: captures a dirty line evicted from the way chosen by the

---
 rtl/cache_victim_writeback.sv | 104 ++++++++++
 tb/tb_cache_victim_writeback.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_victim_writeback.sv
// Victim writeback buffer: holds one evicted dirty line and drains it to the bus
// controller as a burst of AHBW-bit beats, flagging refills that target the same line.
module cache_victim_writeback #(
  parameter int PA_BITS   = 56,
  parameter int LINELEN   = 512,
  parameter int AHBW      = 64,
  parameter int OFFSETLEN = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               VictimValid,
  output logic               VictimReady,
  input  logic [PA_BITS-1:0] VictimAdr,
  input  logic [LINELEN-1:0] VictimLine,
  output logic               BusValid,
  input  logic               BusReady,
  output logic [PA_BITS-1:0] BusAdr,
  output logic [AHBW-1:0]    BusData,
  output logic               BusLast,
  input  logic [PA_BITS-1:0] MatchAdr,
  output logic               MatchHit,
  output logic               Busy
);

  localparam int BEATS     = LINELEN / AHBW;
  localparam int BEAT_BITS = $clog2(BEATS);
  localparam int BYTE_BITS = $clog2(AHBW / 8);
  localparam int TAG_W     = PA_BITS - OFFSETLEN;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [BEAT_BITS-1:0] beat_cnt;
  logic [LINELEN-1:0]   held_line;
  logic [TAG_W-1:0]     held_tag;
  logic                 capture;
  logic                 beat_xfer;
  logic                 last_beat;
  logic                 unused_offset_bits;

  // Offset bits of both addresses are don't-care: everything works on whole lines.
  assign unused_offset_bits = ^{VictimAdr[OFFSETLEN-1:0], MatchAdr[OFFSETLEN-1:0]};

  assign capture   = (state == IDLE) && VictimValid;
  assign beat_xfer = (state == DRAIN) && BusReady;
  assign last_beat = (state == DRAIN) && (beat_cnt == BEAT_BITS'(BEATS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (VictimValid) state_nxt = DRAIN;
      DRAIN:   if (beat_xfer && last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Held line and beat counter; the counter wraps to 0 on the final beat by width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt  <= '0;
      held_line <= '0;
      held_tag  <= '0;
    end else if (capture) begin
      beat_cnt  <= '0;
      held_line <= VictimLine;
      held_tag  <= VictimAdr[PA_BITS-1:OFFSETLEN];
    end else if (beat_xfer) begin
      beat_cnt  <= beat_cnt + 1'b1;
    end
  end

  always_comb begin
    VictimReady = 1'b0;
    BusValid    = 1'b0;
    Busy        = 1'b0;
    BusLast     = 1'b0;
    BusAdr      = '0;
    BusData     = '0;
    MatchHit    = 1'b0;
    case (state)
      IDLE: begin
        VictimReady = 1'b1;
        // Compare against the incoming line too, so the capture cycle is covered.
        MatchHit    = VictimValid &&
                      (MatchAdr[PA_BITS-1:OFFSETLEN] == VictimAdr[PA_BITS-1:OFFSETLEN]);
      end
      DRAIN: begin
        BusValid = 1'b1;
        Busy     = 1'b1;
        BusLast  = last_beat;
        BusAdr   = {held_tag, beat_cnt, {BYTE_BITS{1'b0}}};
        BusData  = held_line[int'(beat_cnt)*AHBW +: AHBW];
        MatchHit = (MatchAdr[PA_BITS-1:OFFSETLEN] == held_tag);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_victim_writeback.sv
// Directed bench for cache_victim_writeback: reset, single burst, backpressure,
// address conflict, back-to-back lines, offset masking and reset mid-burst.
module tb_cache_victim_writeback;

  logic         clk = 1'b0;
  logic         reset;
  logic         VictimValid;
  logic         VictimReady;
  logic [55:0]  VictimAdr;
  logic [511:0] VictimLine;
  logic         BusValid;
  logic         BusReady;
  logic [55:0]  BusAdr;
  logic [63:0]  BusData;
  logic         BusLast;
  logic [55:0]  MatchAdr;
  logic         MatchHit;
  logic         Busy;

  int checks = 0;
  int errors = 0;

  cache_victim_writeback #(
    .PA_BITS(56), .LINELEN(512), .AHBW(64), .OFFSETLEN(6)
  ) dut (
    .clk(clk), .reset(reset),
    .VictimValid(VictimValid), .VictimReady(VictimReady),
    .VictimAdr(VictimAdr), .VictimLine(VictimLine),
    .BusValid(BusValid), .BusReady(BusReady),
    .BusAdr(BusAdr), .BusData(BusData), .BusLast(BusLast),
    .MatchAdr(MatchAdr), .MatchHit(MatchHit), .Busy(Busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byte_of(int pat, int i);
    case (pat)
      0:       return 8'(i);
      1:       return 8'(255 - i);
      default: return 8'(i * 3 + 17);
    endcase
  endfunction

  function automatic logic [511:0] line_of(int pat);
    logic [511:0] l;
    for (int i = 0; i < 64; i++) l[8*i +: 8] = byte_of(pat, i);
    return l;
  endfunction

  function automatic logic [63:0] word_of(int pat, int k);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = byte_of(pat, 8*k + j);
    return w;
  endfunction

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chka(string tag, logic [55:0] obs, logic [55:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    VictimValid = 1'b0;
    VictimAdr   = '0;
    VictimLine  = '0;
    BusReady    = 1'b0;
    MatchAdr    = '0;

    // Reset values
    @(negedge clk); #1;
    chk1("rst_vready", VictimReady, 1'b1);
    chk1("rst_bvalid", BusValid, 1'b0);
    chk1("rst_blast", BusLast, 1'b0);
    chk1("rst_match", MatchHit, 1'b0);
    chk1("rst_busy", Busy, 1'b0);
    chka("rst_badr", BusAdr, 56'h0);
    chkd("rst_bdata", BusData, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Single line, BusReady always high, conflict address inside the line
    VictimValid = 1'b1;
    VictimAdr   = 56'h8000_0040;
    VictimLine  = line_of(0);
    MatchAdr    = 56'h8000_0058;
    BusReady    = 1'b1;
    #1;
    chk1("cap_vready", VictimReady, 1'b1);
    chk1("cap_bvalid", BusValid, 1'b0);
    chk1("cap_match", MatchHit, 1'b1);
    @(negedge clk);
    VictimValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk1("s_bvalid", BusValid, 1'b1);
      chk1("s_vready", VictimReady, 1'b0);
      chk1("s_busy", Busy, 1'b1);
      chka("s_badr", BusAdr, 56'h8000_0040 + 56'(8 * k));
      chkd("s_bdata", BusData, word_of(0, k));
      chk1("s_blast", BusLast, k == 7);
      chk1("s_match", MatchHit, 1'b1);
      if (k == 0) chkd("s_word0", BusData, 64'h0706_0504_0302_0100);
      if (k == 7) chkd("s_word7", BusData, 64'h3F3E_3D3C_3B3A_3938);
      @(negedge clk);
    end
    #1;
    chk1("s_idle_bvalid", BusValid, 1'b0);
    chk1("s_idle_vready", VictimReady, 1'b1);
    chk1("s_idle_busy", Busy, 1'b0);
    chk1("s_idle_match", MatchHit, 1'b0);
    chk1("s_idle_blast", BusLast, 1'b0);

    // Offset bits ignored, backpressure at beat 2, non-matching refill address
    @(negedge clk);
    VictimValid = 1'b1;
    VictimAdr   = 56'h8000_007F;
    VictimLine  = line_of(1);
    MatchAdr    = 56'h8000_0080;
    BusReady    = 1'b1;
    #1;
    chk1("bp_cap_match", MatchHit, 1'b0);
    @(negedge clk);
    VictimValid = 1'b0;
    #1;
    chka("bp_first_adr", BusAdr, 56'h8000_0040);
    chk1("bp_nomatch", MatchHit, 1'b0);
    @(negedge clk);
    @(negedge clk);
    BusReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk1("bp_bvalid", BusValid, 1'b1);
      chka("bp_badr", BusAdr, 56'h8000_0050);
      chkd("bp_bdata", BusData, word_of(1, 2));
      chk1("bp_blast", BusLast, 1'b0);
      @(negedge clk);
    end
    BusReady = 1'b1;
    for (int k = 2; k < 8; k++) begin
      #1;
      chka("bp_adr", BusAdr, 56'h8000_0040 + 56'(8 * k));
      chkd("bp_data", BusData, word_of(1, k));
      chk1("bp_last", BusLast, k == 7);
      @(negedge clk);
    end
    #1;
    chk1("bp_idle", BusValid, 1'b0);

    // Back-to-back lines: second line held on VictimValid during first drain
    @(negedge clk);
    VictimValid = 1'b1;
    VictimAdr   = 56'h8000_0100;
    VictimLine  = line_of(2);
    MatchAdr    = 56'h8000_0200;
    @(negedge clk);
    VictimAdr   = 56'h8000_0200;
    VictimLine  = line_of(1);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk1("b2b_vready", VictimReady, 1'b0);
      chka("b2b_adr", BusAdr, 56'h8000_0100 + 56'(8 * k));
      chkd("b2b_data", BusData, word_of(2, k));
      chk1("b2b_match", MatchHit, 1'b0);
      @(negedge clk);
    end
    #1;
    chk1("b2b_gap_vready", VictimReady, 1'b1);
    chk1("b2b_gap_bvalid", BusValid, 1'b0);
    chk1("b2b_gap_match", MatchHit, 1'b1);
    @(negedge clk);
    VictimValid = 1'b0;
    #1;
    chk1("b2b_2nd_bvalid", BusValid, 1'b1);
    chka("b2b_2nd_adr", BusAdr, 56'h8000_0200);
    chkd("b2b_2nd_data", BusData, word_of(1, 0));
    chk1("b2b_2nd_match", MatchHit, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chka("b2b_beat2_adr", BusAdr, 56'h8000_0210);

    // Reset asserted mid-cycle during a burst
    #1;
    reset = 1'b1;
    #1;
    chk1("mrst_bvalid", BusValid, 1'b0);
    chk1("mrst_vready", VictimReady, 1'b1);
    chk1("mrst_busy", Busy, 1'b0);
    chk1("mrst_blast", BusLast, 1'b0);
    chka("mrst_badr", BusAdr, 56'h0);
    chkd("mrst_bdata", BusData, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk1("mrst_after_bvalid", BusValid, 1'b0);
    chk1("mrst_after_match", MatchHit, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
